writeback: RTL

//  Final pipeline stage, directly downstream of execute. Consumes one execute result
//  per cycle; it is always ready because execute's result channel is unblockable.

---
 rtl/writeback.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/writeback.sv
// writeback: final pipeline stage; retires execute results, drives the register-file write port, redirects fetch on taken jumps and traps
module writeback #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int              TRAP_HOLD = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            in_epoch_i,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic            in_wb_en_i,
    input  logic [4:0]      in_rd_i,
    input  logic [XLEN-1:0] in_rd_val_i,
    input  logic            in_jump_i,
    input  logic [XLEN-1:0] in_target_i,
    input  logic            in_illegal_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_addr_o,
    output logic [XLEN-1:0] rf_data_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            epoch_o,
    output logic [XLEN-1:0] trap_epc_o,
    output logic [3:0]      trap_cause_o,
    output logic [63:0]     instret_o,
    output logic [31:0]     squashed_o
);
    localparam int            HW             = (TRAP_HOLD > 1) ? $clog2(TRAP_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_INIT      = HW'(TRAP_HOLD - 1);
    localparam logic [0:0]    ST_RUN         = 1'b0;
    localparam logic [0:0]    ST_TRAP        = 1'b1;
    localparam logic [3:0]    CAUSE_MISALIGN = 4'd0;
    localparam logic [3:0]    CAUSE_ILLEGAL  = 4'd2;

    logic [0:0]      state_q, state_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            epoch_q, epoch_d;
    logic            rf_we_q, rf_we_d;
    logic [4:0]      rf_addr_q, rf_addr_d;
    logic [XLEN-1:0] rf_data_q, rf_data_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] trap_epc_q, trap_epc_d;
    logic [3:0]      trap_cause_q, trap_cause_d;
    logic [63:0]     instret_q, instret_d;
    logic [31:0]     squashed_q, squashed_d;

    logic in_run, take, drop, misalign, trap, retire, jump, hold_done;

    // The upstream result channel cannot stall, so this stage never back-pressures.
    assign in_ready_o = 1'b1;

    // A result is taken only while running and only if it belongs to the current epoch.
    assign in_run    = state_q == ST_RUN;
    assign take      = in_valid_i && in_run && (in_epoch_i == epoch_q);
    assign drop      = in_valid_i && !take;
    assign misalign  = in_jump_i && (in_target_i[1:0] != 2'b00);
    assign trap      = take && (in_illegal_i || misalign);
    assign retire    = take && !trap;
    assign jump      = retire && in_jump_i;
    assign hold_done = (state_q == ST_TRAP) && (hold_q == '0);

    // Writes to x0 are suppressed; a taken jump still writes its link register.
    assign rf_we_d   = retire && in_wb_en_i && (in_rd_i != 5'd0);
    assign rf_addr_d = retire ? in_rd_i : rf_addr_q;
    assign rf_data_d = retire ? in_rd_val_i : rf_data_q;

    // Every redirect flips the epoch so results fetched down the old path get dropped.
    assign redirect_d    = trap || jump;
    assign redirect_pc_d = trap ? TRAP_VEC : jump ? in_target_i : redirect_pc_q;
    assign epoch_d       = epoch_q ^ redirect_d;

    // Illegal instruction outranks a misaligned jump target when both occur.
    assign trap_epc_d   = trap ? in_pc_i : trap_epc_q;
    assign trap_cause_d = !trap ? trap_cause_q : in_illegal_i ? CAUSE_ILLEGAL : CAUSE_MISALIGN;

    // instret wraps naturally; squashed saturates so a long drop run cannot alias to a small count.
    assign instret_d  = instret_q + 64'(retire);
    assign squashed_d = (drop && squashed_q != '1) ? squashed_q + 32'd1 : squashed_q;

    // TRAP lasts TRAP_HOLD cycles: the counter loads on entry and we leave the cycle after it reads 0.
    assign state_d = trap ? ST_TRAP : hold_done ? ST_RUN : state_q;
    assign hold_d  = trap ? HOLD_INIT : (state_q == ST_TRAP && hold_q != '0) ? hold_q - HW'(1) : hold_q;

    // Control state: FSM, trap hold counter and epoch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_RUN;
            hold_q  <= '0;
            epoch_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            epoch_q <= epoch_d;
        end
    end

    // Register-file write port, one-cycle write pulse per retired result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
        end
    end

    // Fetch redirect, one-cycle pulse per taken jump or trap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // Trap record, held until the next trap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            trap_epc_q   <= '0;
            trap_cause_q <= '0;
        end else begin
            trap_epc_q   <= trap_epc_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Retired and squashed instruction counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instret_q  <= '0;
            squashed_q <= '0;
        end else begin
            instret_q  <= instret_d;
            squashed_q <= squashed_d;
        end
    end

    assign rf_we_o       = rf_we_q;
    assign rf_addr_o     = rf_addr_q;
    assign rf_data_o     = rf_data_q;
    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign epoch_o       = epoch_q;
    assign trap_epc_o    = trap_epc_q;
    assign trap_cause_o  = trap_cause_q;
    assign instret_o     = instret_q;
    assign squashed_o    = squashed_q;
endmodule
